// File: rtl/ram_read_arbiter_pkg.sv
// Shared types and defaults for the two-port byte-serial RAM read arbiter.
// Port 0 is instruction fetch, port 1 is data load.
package ram_read_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int BYTES_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACK
    } arbState_t;

    typedef logic portId_t;

    localparam portId_t PORT_FETCH = 1'b0;
    localparam portId_t PORT_DATA  = 1'b1;

    function automatic portId_t otherPort(input portId_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/ram_read_arbiter_word_assembler.sv
// Little-endian word assembly from a byte stream: each capture writes one byte lane.
// `assembled` already includes a byte being captured this cycle, so a caller can take the full word on the last capture.
module word_assembler #(
    parameter int BYTES  = 4,
    parameter int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 captureEn,
    input  logic [LANE_W-1:0]    lane,
    input  logic [7:0]           byteIn,
    output logic [8*BYTES-1:0]   assembled
);

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        logic       hit;
        logic [7:0] laneReg;

        assign hit = captureEn && (lane == LANE_W'(gi));
        assign assembled[8*gi +: 8] = hit ? byteIn : laneReg;

        always_ff @(posedge clk) begin
            if (reset) begin
                laneReg <= '0;
            end else if (hit) begin
                laneReg <= byteIn;
            end
        end
    end

endmodule

// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read byte RAM between fetch and load ports.
// Each grant issues BYTES consecutive byte reads and returns a little-endian word with a one-cycle ack.
module ram_read_arbiter
    import ram_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYTES  = BYTES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                readReq0,
    input  logic [ADDR_W-1:0]   readAddr0,
    output logic                readAck0,
    output logic [8*BYTES-1:0]  readValue0,
    input  logic                readReq1,
    input  logic [ADDR_W-1:0]   readAddr1,
    output logic                readAck1,
    output logic [8*BYTES-1:0]  readValue1,
    output logic [ADDR_W-1:0]   ramAddress,
    output logic                ramReadEn,
    input  logic [7:0]          ramData,
    output logic                busy,
    output logic                grantId
);

    localparam int W      = 8 * BYTES;
    localparam int CNT_W  = $clog2(BYTES + 1);
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    arbState_t           stateReg, stateNext;
    logic [CNT_W-1:0]    cntReg, cntNext;
    logic [ADDR_W-1:0]   baseReg, baseNext;
    portId_t             grantReg, grantNext;
    portId_t             lastGrantReg, lastGrantNext;
    logic [W-1:0]        value0Reg, value1Reg;
    logic [W-1:0]        assembled;
    logic                captureEn;
    logic                loadValue;
    logic [LANE_W-1:0]   lane;

    word_assembler #(
        .BYTES  (BYTES),
        .LANE_W (LANE_W)
    ) u_assembler (
        .clk       (clk),
        .reset     (reset),
        .captureEn (captureEn),
        .lane      (lane),
        .byteIn    (ramData),
        .assembled (assembled)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            baseReg      <= '0;
            grantReg     <= PORT_FETCH;
            lastGrantReg <= PORT_DATA;
            value0Reg    <= '0;
            value1Reg    <= '0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            baseReg      <= baseNext;
            grantReg     <= grantNext;
            lastGrantReg <= lastGrantNext;
            if (loadValue) begin
                if (grantReg == PORT_FETCH) begin
                    value0Reg <= assembled;
                end else begin
                    value1Reg <= assembled;
                end
            end
        end
    end

    // cntReg walks 0..BYTES in READ: issue byte cnt while cnt<BYTES, capture lane cnt-1 while cnt>0.
    always_comb begin
        stateNext     = stateReg;
        cntNext       = cntReg;
        baseNext      = baseReg;
        grantNext     = grantReg;
        lastGrantNext = lastGrantReg;
        captureEn     = 1'b0;
        loadValue     = 1'b0;
        lane          = '0;

        case (stateReg)
            IDLE: begin
                if (readReq0 || readReq1) begin
                    if (readReq0 && readReq1) begin
                        grantNext = otherPort(lastGrantReg);
                    end else if (readReq1) begin
                        grantNext = PORT_DATA;
                    end else begin
                        grantNext = PORT_FETCH;
                    end
                    baseNext  = (grantNext == PORT_DATA) ? readAddr1 : readAddr0;
                    cntNext   = '0;
                    stateNext = READ;
                end
            end
            READ: begin
                cntNext = cntReg + CNT_W'(1);
                if (cntReg != '0) begin
                    captureEn = 1'b1;
                    lane      = LANE_W'(cntReg - CNT_W'(1));
                end
                if (cntReg == CNT_W'(BYTES)) begin
                    loadValue = 1'b1;
                    stateNext = ACK;
                end
            end
            ACK: begin
                lastGrantNext = grantReg;
                stateNext     = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign busy       = (stateReg != IDLE);
    assign ramReadEn  = (stateReg == READ) && (cntReg < CNT_W'(BYTES));
    assign ramAddress = ramReadEn ? (baseReg + ADDR_W'(cntReg)) : '0;
    assign readAck0   = (stateReg == ACK) && (grantReg == PORT_FETCH);
    assign readAck1   = (stateReg == ACK) && (grantReg == PORT_DATA);
    assign readValue0 = value0Reg;
    assign readValue1 = value1Reg;
    assign grantId    = grantReg;

endmodule
